// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - instruction-memory responder with fixed wait states and preload port
// Optional macro IMEM_MISALIGN_CHECK_EN turns misaligned fetches into access faults.
module imem_responder #(
  parameter int DEPTH       = 256,
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic              rsp_err,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  output logic              stat_busy
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam logic [29:0] DEPTH_W = 30'(DEPTH);

  state_t      state;
  logic [3:0]  cnt;
  logic [29:0] pend_idx;
  logic        fault;
  logic [31:0] mem [DEPTH];

  // No reset on the array: preloaded program survives a reset.
  always_ff @(posedge clk) begin
    if (load_we) mem[load_addr] <= load_data;
  end

`ifdef IMEM_MISALIGN_CHECK_EN
  logic pend_mis;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pend_mis <= 1'b0;
    else if (state == S_IDLE && req_valid && req_ready) pend_mis <= |req_addr[1:0];
  end

  assign fault = (pend_idx >= DEPTH_W) || pend_mis;
`else
  logic unused_low_bits;
  assign unused_low_bits = ^req_addr[1:0];
  assign fault = (pend_idx >= DEPTH_W);
`endif

  // The counter is 0 on the edge that enters RESP, giving WAIT_CYCLES+1 cycles of latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      pend_idx  <= 30'd0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= 32'd0;
      rsp_err   <= 1'b0;
      stat_busy <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            pend_idx  <= req_addr[31:2];
            cnt       <= 4'(WAIT_CYCLES);
            state     <= S_WAIT;
            req_ready <= 1'b0;
            stat_busy <= 1'b1;
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= fault;
            rsp_data  <= fault ? 32'd0 : mem[pend_idx[ADDR_W-1:0]];
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
            req_ready <= 1'b1;
            stat_busy <= 1'b0;
          end
        end
        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          stat_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - directed bench for imem_responder (WAIT_CYCLES=1 and WAIT_CYCLES=3 instances)
module tb_imem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_err, stat_busy;
  logic [31:0] req_addr, rsp_data;
  logic        b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready, b_rsp_err, b_stat_busy;
  logic [31:0] b_req_addr, b_rsp_data;
  logic        load_we;
  logic [7:0]  load_addr;
  logic [31:0] load_data;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  imem_responder #(.DEPTH(256), .ADDR_W(8), .WAIT_CYCLES(1)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data), .stat_busy(stat_busy)
  );

  imem_responder #(.DEPTH(256), .ADDR_W(8), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_addr(b_req_addr),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data), .rsp_err(b_rsp_err),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data), .stat_busy(b_stat_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    load_we = 1'b1; load_addr = a; load_data = d;
    tick();
    load_we = 1'b0;
  endtask

  // WAIT_CYCLES=1 instance: accept, two-cycle latency, immediate handshake.
  task automatic fetch(input string tag, input logic [31:0] a, input logic [31:0] exp_d, input logic exp_e);
    req_valid = 1'b1; req_addr = a; rsp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    check({tag, "_busy"}, 32'(stat_busy), 32'd1);
    check({tag, "_rdy0"}, 32'(req_ready), 32'd0);
    check({tag, "_v_t0"}, 32'(rsp_valid), 32'd0);
    tick();
    check({tag, "_v_t1"}, 32'(rsp_valid), 32'd0);
    tick();
    check({tag, "_v_t2"}, 32'(rsp_valid), 32'd1);
    check({tag, "_data"}, rsp_data, exp_d);
    check({tag, "_err"}, 32'(rsp_err), 32'(exp_e));
    tick();
    check({tag, "_v_done"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rdy_back"}, 32'(req_ready), 32'd1);
    check({tag, "_idle"}, 32'(stat_busy), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_addr = 32'd0; rsp_ready = 1'b0;
    b_req_valid = 1'b0; b_req_addr = 32'd0; b_rsp_ready = 1'b1;
    load_we = 1'b0; load_addr = 8'd0; load_data = 32'd0;
    tick();
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_data", rsp_data, 32'd0);
    check("rst_err", 32'(rsp_err), 32'd0);
    check("rst_busy", 32'(stat_busy), 32'd0);
    reset = 1'b0;
    tick();
    check("rst_ready", 32'(req_ready), 32'd1);

    preload(8'd4, 32'h00500093);
    preload(8'd2, 32'hAAAA0001);
    preload(8'd6, 32'h66660000);
    preload(8'd255, 32'hDEADBEEF);

    fetch("basic", 32'h10, 32'h00500093, 1'b0);

    // Back-pressure: response held for 5 cycles, competing request and array write ignored.
    req_valid = 1'b1; req_addr = 32'h10; rsp_ready = 1'b0;
    tick();
    req_addr = 32'h0;
    tick();
    tick();
    check("bp_valid_rise", 32'(rsp_valid), 32'd1);
    load_we = 1'b1; load_addr = 8'd4; load_data = 32'h11111111;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid_hold", 32'(rsp_valid), 32'd1);
      check("bp_data_hold", rsp_data, 32'h00500093);
      check("bp_no_accept", 32'(req_ready), 32'd0);
      tick();
      load_we = 1'b0;
    end
    rsp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    check("bp_release_valid", 32'(rsp_valid), 32'd0);
    check("bp_release_ready", 32'(req_ready), 32'd1);
    preload(8'd4, 32'h00500093);

    fetch("range_fault", 32'h400, 32'h0, 1'b1);
    fetch("last_word", 32'h3FC, 32'hDEADBEEF, 1'b0);

    // Write on the RESP-entry edge: old data returned, new data on the next fetch.
    req_valid = 1'b1; req_addr = 32'h18; rsp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    load_we = 1'b1; load_addr = 8'd6; load_data = 32'h77770000;
    tick();
    load_we = 1'b0;
    check("rbw_valid", 32'(rsp_valid), 32'd1);
    check("rbw_old_data", rsp_data, 32'h66660000);
    tick();
    fetch("rbw_new", 32'h18, 32'h77770000, 1'b0);

    // WAIT_CYCLES=3: write during first WAIT cycle is visible, 4-cycle latency.
    b_req_valid = 1'b1; b_req_addr = 32'h8;
    tick();
    b_req_valid = 1'b0;
    load_we = 1'b1; load_addr = 8'd2; load_data = 32'hBBBB0002;
    tick();
    load_we = 1'b0;
    check("w3_v_t1", 32'(b_rsp_valid), 32'd0);
    tick();
    check("w3_v_t2", 32'(b_rsp_valid), 32'd0);
    tick();
    check("w3_v_t3", 32'(b_rsp_valid), 32'd0);
    tick();
    check("w3_v_t4", 32'(b_rsp_valid), 32'd1);
    check("w3_data", b_rsp_data, 32'hBBBB0002);
    check("w3_err", 32'(b_rsp_err), 32'd0);
    tick();
    check("w3_done", 32'(b_rsp_valid), 32'd0);
    check("w3_ready", 32'(b_req_ready), 32'd1);

    // Reset while waiting drops the request.
    req_valid = 1'b1; req_addr = 32'h10; rsp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    check("mid_busy", 32'(stat_busy), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", 32'(stat_busy), 32'd0);
    check("mid_rst_valid", 32'(rsp_valid), 32'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mid_no_rsp", 32'(rsp_valid), 32'd0);
    end
    fetch("after_rst", 32'h10, 32'h00500093, 1'b0);

`ifdef IMEM_MISALIGN_CHECK_EN
    fetch("misalign", 32'h12, 32'h0, 1'b1);
    fetch("misalign_range", 32'h401, 32'h0, 1'b1);
`else
    fetch("misalign", 32'h12, 32'h00500093, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
